// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store access unit between the pipeline MEM stage and a word-wide data
//   memory. It turns byte/halfword/word requests into word-aligned memory
//   accesses. Sub-word stores use a read-modify-write. Loads are lane-extracted
//   and sign/zero extended. Misaligned or reserved-size requests are answered
//   with resp_err and never touch memory.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
//   req_ready is high in IDLE and RESP only. The requester holds req_* stable
//   until that edge. Every accepted request yields exactly one resp_valid cycle;
//   resp_err/resp_rdata are meaningful only while resp_valid is high.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_write, req_size,         store/load, 00 byte 01 half 10 word 11 reserved,
//   req_unsigned, req_addr,      zero-extend loads, byte address,
//   req_wdata                    right-justified store data
//   resp_valid, resp_err,        one-cycle completion, error flag,
//   resp_rdata                   extended load data
//   mem_read_en, mem_write_en,   memory enables (forced low while rst_n is low)
//   mem_addr, mem_write_data,    word address, write word
//   mem_read_data                combinational read word for mem_addr
module mem_access_unit #(
  parameter int ADDR_SIZE  = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [31:0]          resp_rdata,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [31:0]          mem_write_data,
  input  logic [31:0]          mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_STORE_RD = 3'd2,
    S_STORE_WR = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [ADDR_SIZE+1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          merge_q, merge_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 misaligned;
  logic                 rd_en, wr_en;
  logic [4:0]           shift;
  logic [31:0]          shifted;
  logic [31:0]          load_ext;
  logic [31:0]          lane_mask;
  logic [31:0]          merged;

  // Address bits above the memory depth are dropped, so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_SIZE+2];

  // Bit position of the addressed lane inside the memory word.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] lane;
    if (size == SZ_BYTE) begin
      lane = BIG_ENDIAN ? (2'd3 - off) : off;
    end else if (size == SZ_HALF) begin
      lane = BIG_ENDIAN ? (2'd2 - off) : off;
    end else begin
      lane = 2'd0;
    end
    return {lane, 3'b000};
  endfunction

  assign req_ready = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    shift   = lane_shift(size_q, addr_q[1:0]);
    shifted = mem_read_data >> shift;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'b0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = uns_q ? {16'b0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
    lane_mask = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
    merged    = (merge_q & ~lane_mask) | ((wdata_q << shift) & lane_mask);
  end

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    merge_d        = merge_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    rd_en          = 1'b0;
    wr_en          = 1'b0;
    mem_addr       = '0;
    mem_write_data = 32'b0;
    resp_valid     = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        rd_en    = 1'b1;
        mem_addr = addr_q[ADDR_SIZE+1:2];
        rdata_d  = load_ext;
        state_d  = S_RESP;
      end
      S_STORE_RD: begin
        rd_en    = 1'b1;
        mem_addr = addr_q[ADDR_SIZE+1:2];
        merge_d  = mem_read_data;
        state_d  = S_STORE_WR;
      end
      S_STORE_WR: begin
        wr_en          = 1'b1;
        mem_addr       = addr_q[ADDR_SIZE+1:2];
        mem_write_data = (size_q == SZ_WORD) ? wdata_q : merged;
        state_d        = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance is only possible in IDLE or RESP and overrides the
    // default next state of either.
    if (accept) begin
      write_d = req_write;
      size_d  = req_size;
      uns_d   = req_unsigned;
      addr_d  = req_addr[ADDR_SIZE+1:0];
      wdata_d = req_wdata;
      err_d   = misaligned;
      // Stores and errors respond with zero data; loads overwrite in LOAD.
      if (misaligned || req_write) begin
        rdata_d = 32'b0;
      end
      if (misaligned) begin
        state_d = S_RESP;
      end else if (!req_write) begin
        state_d = S_LOAD;
      end else if (req_size == SZ_WORD) begin
        state_d = S_STORE_WR;
      end else begin
        state_d = S_STORE_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      merge_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // write_q is latched with the request for completeness; the datapath
  // decisions are already encoded in the state sequence.
  logic unused_write;
  assign unused_write = write_q;

  // Enables are gated by reset so a reset landing mid-access writes nothing.
  assign mem_read_en  = rd_en & rst_n;
  assign mem_write_en = wr_en & rst_n;
  assign resp_err     = resp_valid & err_q;
  assign resp_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared request inputs ----------------
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;

  // ---------------- big-endian instance ----------------
  logic        req_ready_be, resp_valid_be, resp_err_be;
  logic [31:0] resp_rdata_be;
  logic        mem_read_en_be, mem_write_en_be;
  logic [7:0]  mem_addr_be;
  logic [31:0] mem_write_data_be, mem_read_data_be;
  logic [31:0] mem_be [256];

  mem_access_unit #(.ADDR_SIZE(8), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_be), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid_be), .resp_err(resp_err_be), .resp_rdata(resp_rdata_be),
    .mem_read_en(mem_read_en_be), .mem_write_en(mem_write_en_be),
    .mem_addr(mem_addr_be), .mem_write_data(mem_write_data_be),
    .mem_read_data(mem_read_data_be)
  );

  // ---------------- little-endian instance ----------------
  logic        req_ready_le, resp_valid_le, resp_err_le;
  logic [31:0] resp_rdata_le;
  logic        mem_read_en_le, mem_write_en_le;
  logic [7:0]  mem_addr_le;
  logic [31:0] mem_write_data_le, mem_read_data_le;
  logic [31:0] mem_le [256];

  mem_access_unit #(.ADDR_SIZE(8), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_le), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid_le), .resp_err(resp_err_le), .resp_rdata(resp_rdata_le),
    .mem_read_en(mem_read_en_le), .mem_write_en(mem_write_en_le),
    .mem_addr(mem_addr_le), .mem_write_data(mem_write_data_le),
    .mem_read_data(mem_read_data_le)
  );

  // ---------------- memory models ----------------
  assign mem_read_data_be = mem_be[mem_addr_be];
  assign mem_read_data_le = mem_le[mem_addr_le];

  always @(posedge clk) begin
    if (mem_write_en_be) mem_be[mem_addr_be] <= mem_write_data_be;
    if (mem_write_en_le) mem_le[mem_addr_le] <= mem_write_data_le;
  end

  // Enable activity of the big-endian instance, sampled mid-cycle.
  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (mem_read_en_be)  rd_cnt++;
    if (mem_write_en_be) wr_cnt++;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request from IDLE and waits (bounded) for each instance's
  // response. Latency counts the acceptance cycle as 0; -1 means no response.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat_be, output int lat_le,
                         output logic [31:0] rd_be, output logic [31:0] rd_le,
                         output logic err_be, output logic err_le);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat_be = -1; lat_le = -1;
    rd_be = 32'hXXXX_XXXX; rd_le = 32'hXXXX_XXXX;
    err_be = 1'bx; err_le = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid_be && lat_be < 0) begin
        lat_be = c; rd_be = resp_rdata_be; err_be = resp_err_be;
      end
      if (resp_valid_le && lat_le < 0) begin
        lat_le = c; rd_le = resp_rdata_le; err_le = resp_err_le;
      end
      if (lat_be >= 0 && lat_le >= 0) break;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_be;
    logic [31:0] exp_le;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_vec(logic w, logic [1:0] sz, logic u, logic [31:0] a,
                                  logic [31:0] wd, logic [31:0] eb, logic [31:0] el,
                                  logic e, int lat, int rd, int wr);
    vec_t v;
    v.write = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_be = eb; v.exp_le = el; v.exp_err = e; v.exp_lat = lat;
    v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lb, ll, rb, wb, c, pulses, p1, p2;
    logic [31:0] db, dl, r1, r2;
    logic        eb, el, acc;

    for (int i = 0; i < 256; i++) begin
      mem_be[i] = 32'b0;
      mem_le[i] = 32'b0;
    end

    //           wr  size  uns addr          wdata         exp_be        exp_le        err lat rd wr
    vecs.push_back(mk_vec(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        32'h0,        0, 2, 0, 1));
    vecs.push_back(mk_vec(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 2, 1, 0));
    vecs.push_back(mk_vec(1, 2'b00, 0, 32'h11,  32'hFFFFFF5A, 32'h0,        32'h0,        0, 3, 1, 1));
    vecs.push_back(mk_vec(0, 2'b10, 0, 32'h10,  32'h0,        32'hDE5ABEEF, 32'hDEAD5AEF, 0, 2, 1, 0));
    vecs.push_back(mk_vec(0, 2'b00, 0, 32'h12,  32'h0,        32'hFFFFFFBE, 32'hFFFFFFAD, 0, 2, 1, 0));
    vecs.push_back(mk_vec(0, 2'b00, 1, 32'h12,  32'h0,        32'h000000BE, 32'h000000AD, 0, 2, 1, 0));
    vecs.push_back(mk_vec(0, 2'b01, 0, 32'h10,  32'h0,        32'hFFFFDE5A, 32'h00005AEF, 0, 2, 1, 0));
    vecs.push_back(mk_vec(0, 2'b01, 1, 32'h12,  32'h0,        32'h0000BEEF, 32'h0000DEAD, 0, 2, 1, 0));
    vecs.push_back(mk_vec(0, 2'b01, 0, 32'h11,  32'h0,        32'h0,        32'h0,        1, 1, 0, 0));
    vecs.push_back(mk_vec(1, 2'b10, 0, 32'h12,  32'h11111111, 32'h0,        32'h0,        1, 1, 0, 0));
    vecs.push_back(mk_vec(0, 2'b11, 0, 32'h10,  32'h0,        32'h0,        32'h0,        1, 1, 0, 0));
    vecs.push_back(mk_vec(0, 2'b10, 0, 32'h10,  32'h0,        32'hDE5ABEEF, 32'hDEAD5AEF, 0, 2, 1, 0));
    vecs.push_back(mk_vec(1, 2'b10, 0, 32'h410, 32'h01234567, 32'h0,        32'h0,        0, 2, 0, 1));
    vecs.push_back(mk_vec(0, 2'b10, 0, 32'h10,  32'h0,        32'h01234567, 32'h01234567, 0, 2, 1, 0));
    vecs.push_back(mk_vec(1, 2'b01, 0, 32'h12,  32'h9999ABCD, 32'h0,        32'h0,        0, 3, 1, 1));
    vecs.push_back(mk_vec(0, 2'b10, 0, 32'h410, 32'h0,        32'h0123ABCD, 32'hABCD4567, 0, 2, 1, 0));
    vecs.push_back(mk_vec(0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFFCD, 32'hFFFFFFAB, 0, 2, 1, 0));
    vecs.push_back(mk_vec(0, 2'b01, 0, 32'h10,  32'h0,        32'h00000123, 32'h00004567, 0, 2, 1, 0));
    vecs.push_back(mk_vec(0, 2'b00, 1, 32'h10,  32'h0,        32'h00000001, 32'h00000067, 0, 2, 1, 0));

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready",      {31'b0, req_ready_be},      32'h1);
    check("rst resp_valid",     {31'b0, resp_valid_be},     32'h0);
    check("rst resp_err",       {31'b0, resp_err_be},       32'h0);
    check("rst resp_rdata",     resp_rdata_be,              32'h0);
    check("rst mem_read_en",    {31'b0, mem_read_en_be},    32'h0);
    check("rst mem_write_en",   {31'b0, mem_write_en_be},   32'h0);
    check("rst mem_addr",       {24'b0, mem_addr_be},       32'h0);
    check("rst mem_write_data", mem_write_data_be,          32'h0);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      rb = rd_cnt; wb = wr_cnt;
      run_req(vecs[i].write, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              lb, ll, db, dl, eb, el);
      check($sformatf("v%0d lat_be", i),   lb,            vecs[i].exp_lat);
      check($sformatf("v%0d lat_le", i),   ll,            vecs[i].exp_lat);
      check($sformatf("v%0d err_be", i),   {31'b0, eb},   {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d err_le", i),   {31'b0, el},   {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d rdata_be", i), db,            vecs[i].exp_be);
      check($sformatf("v%0d rdata_le", i), dl,            vecs[i].exp_le);
      check($sformatf("v%0d rd_cycles", i), rd_cnt - rb,  vecs[i].exp_rd);
      check($sformatf("v%0d wr_cycles", i), wr_cnt - wb,  vecs[i].exp_wr);
    end

    // ---- reset landing in STORE_WR of a halfword store ----
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00001234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t5 store_rd read_en", {31'b0, mem_read_en_be}, 32'h1);
    @(negedge clk);
    check("t5 store_wr write_en", {31'b0, mem_write_en_be}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5 gated write_en_be", {31'b0, mem_write_en_be}, 32'h0);
    check("t5 gated write_en_le", {31'b0, mem_write_en_le}, 32'h0);
    @(negedge clk);
    check("t5 post rst resp_valid", {31'b0, resp_valid_be}, 32'h0);
    check("t5 post rst resp_rdata", resp_rdata_be,          32'h0);
    check("t5 post rst req_ready",  {31'b0, req_ready_be},  32'h1);
    check("t5 post rst read_en",    {31'b0, mem_read_en_be}, 32'h0);
    rst_n = 1'b1;
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lb, ll, db, dl, eb, el);
    check("t5 lw after rst be", db, 32'h0123ABCD);
    check("t5 lw after rst le", dl, 32'hABCD4567);

    // ---- back-to-back with req_valid held high ----
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_write = 1'b0; req_wdata = 32'h0;
    pulses = 0; p1 = -1; p2 = -1; r1 = 32'hX; r2 = 32'hX;
    for (c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) check("t6 busy req_ready", {31'b0, req_ready_be}, 32'h0);
      if (resp_valid_be) begin
        pulses++;
        if (p1 < 0) begin p1 = c; r1 = resp_rdata_be; end
        else begin p2 = c; r2 = resp_rdata_be; end
      end
      acc = req_valid && req_ready_be;
      @(posedge clk); #1;
      if (acc) req_valid = 1'b0;
    end
    check("t6 pulse count", pulses, 2);
    check("t6 first resp cycle", p1, 2);
    check("t6 second resp cycle", p2, 4);
    check("t6 store rdata", r1, 32'h0);
    check("t6 load rdata", r2, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
